// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// io_sub is present only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             io_in_valid;
  logic             io_in_ready;
  logic [WIDTH-1:0] io_lhs;
  logic [WIDTH-1:0] io_rhs;
  logic             io_cin;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [WIDTH-1:0] io_out;
  logic             io_cout;
`ifdef SERIAL_ADDER_SUB_EN
  logic             io_sub;

  modport master (
    output io_in_valid, io_lhs, io_rhs, io_cin, io_sub, io_out_ready,
    input  io_in_ready, io_out_valid, io_out, io_cout
  );
  modport slave (
    input  io_in_valid, io_lhs, io_rhs, io_cin, io_sub, io_out_ready,
    output io_in_ready, io_out_valid, io_out, io_cout
  );
`else
  modport master (
    output io_in_valid, io_lhs, io_rhs, io_cin, io_out_ready,
    input  io_in_ready, io_out_valid, io_out, io_cout
  );
  modport slave (
    input  io_in_valid, io_lhs, io_rhs, io_cin, io_out_ready,
    output io_in_ready, io_out_valid, io_out, io_cout
  );
`endif
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH-bit add of lhs + rhs + cin, DIGIT bits per cycle.
// Define SERIAL_ADDER_SUB_EN to add io_sub (lhs - rhs - cin, cout=1 means no borrow).
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input logic           clk,
  input logic           reset,
  serial_adder_if.slave bus
);
  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] lhs_q;
  logic [WIDTH-1:0] rhs_q;
  logic [WIDTH-1:0] out_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [WIDTH-1:0] rhs_d;
  logic             cin_d;
  logic [DIGIT:0]   dsum_d;

  // Subtraction folds into the add by inverting rhs and cin at capture.
`ifdef SERIAL_ADDER_SUB_EN
  assign rhs_d = bus.io_sub ? ~bus.io_rhs : bus.io_rhs;
  assign cin_d = bus.io_cin ^ bus.io_sub;
`else
  assign rhs_d = bus.io_rhs;
  assign cin_d = bus.io_cin;
`endif

  // Operands shift right so the current digit is always in the low bits.
  assign dsum_d = {1'b0, lhs_q[DIGIT-1:0]} + {1'b0, rhs_q[DIGIT-1:0]}
                + (DIGIT+1)'(carry_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lhs_q       <= '0;
      rhs_q       <= '0;
      out_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.io_in_valid) begin
            lhs_q      <= bus.io_lhs;
            rhs_q      <= rhs_d;
            carry_q    <= cin_d;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          // Sum digits enter at the top and walk down to their final position.
          lhs_q   <= lhs_q >> DIGIT;
          rhs_q   <= rhs_q >> DIGIT;
          out_q   <= (out_q >> DIGIT) | (WIDTH'(dsum_d[DIGIT-1:0]) << (WIDTH - DIGIT));
          carry_q <= dsum_d[DIGIT];
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            cout_q      <= dsum_d[DIGIT];
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.io_out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.io_in_ready  = in_ready_q;
  assign bus.io_out_valid = out_valid_q;
  assign bus.io_out       = out_q;
  assign bus.io_cout      = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed vector table, multi-cycle corner cases and a
// randomized scoreboard across three DIGIT configurations (2, 8, 1) at WIDTH=8.
module tb_serial_adder;
  localparam int NI = 3;

  logic       clk;
  logic       reset;
  logic       in_valid  [NI];
  logic       in_ready  [NI];
  logic [7:0] lhs       [NI];
  logic [7:0] rhs       [NI];
  logic       cin       [NI];
  logic       sub       [NI];
  logic       out_valid [NI];
  logic       out_ready [NI];
  logic [7:0] out       [NI];
  logic       cout      [NI];

  int checks;
  int failures;

  logic [8:0] exp_mem [NI][0:4095];
  int         wr_i [NI];
  int         rd_i [NI];
  int         total_acc;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned DG = (g == 0) ? 2 : ((g == 1) ? 8 : 1);
    serial_adder_if #(.WIDTH(8)) bus ();
    serial_adder #(.WIDTH(8), .DIGIT(DG)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
    assign bus.io_in_valid  = in_valid[g];
    assign bus.io_lhs       = lhs[g];
    assign bus.io_rhs       = rhs[g];
    assign bus.io_cin       = cin[g];
    assign bus.io_out_ready = out_ready[g];
`ifdef SERIAL_ADDER_SUB_EN
    assign bus.io_sub       = sub[g];
`endif
    assign in_ready[g]  = bus.io_in_ready;
    assign out_valid[g] = bus.io_out_valid;
    assign out[g]       = bus.io_out;
    assign cout[g]      = bus.io_cout;
  end

  always #5 clk = ~clk;

  typedef struct {
    int         k;
    logic [7:0] l;
    logic [7:0] r;
    logic       c;
    int         hold;
    logic [8:0] e;
  } vec_t;

  vec_t tbl [8];

  function automatic int nd(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 1 : 8);
  endfunction

  // Reference: plain integer arithmetic on the spec's definition.
  function automatic logic [8:0] model(input logic [7:0] l, input logic [7:0] r,
                                       input logic c, input logic s);
    int a;
    if (s) begin
      a = int'(l) - int'(r) - int'(c);
      return {(a >= 0), 8'(a)};
    end
    a = int'(l) + int'(r) + int'(c);
    return 9'(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < NI; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b0;
      lhs[k]       = 8'h00;
      rhs[k]       = 8'h00;
      cin[k]       = 1'b0;
      sub[k]       = 1'b0;
    end
  endtask

  // One transaction on instance k with `hold` cycles of backpressure in DONE.
  task automatic run_op(input int k, input logic [7:0] l, input logic [7:0] r,
                        input logic c, input logic s, input int hold, input logic [8:0] e);
    int cnt;
    chk("in_ready_idle", 32'(in_ready[k]), 32'd1);
    lhs[k] = l; rhs[k] = r; cin[k] = c; sub[k] = s;
    in_valid[k] = 1'b1; out_ready[k] = 1'b0;
    step();
    // keep valid high with scrambled operands: must be ignored after capture
    lhs[k] = ~l; rhs[k] = ~r; cin[k] = ~c; sub[k] = ~s;
    cnt = 0;
    while (out_valid[k] !== 1'b1 && cnt < 20) begin
      chk("in_ready_busy", 32'(in_ready[k]), 32'd0);
      step();
      cnt++;
    end
    chk("latency", 32'(cnt), 32'(nd(k)));
    chk("sum", 32'({cout[k], out[k]}), 32'(e));
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_stable", 32'({out_valid[k], in_ready[k], cout[k], out[k]}),
          32'({1'b1, 1'b0, e}));
    end
    in_valid[k] = 1'b0; out_ready[k] = 1'b1;
    step();
    chk("release_idle", 32'({out_valid[k], in_ready[k]}), 32'd1);
    out_ready[k] = 1'b0;
  endtask

  task automatic tput(input int k);
    int hits [2];
    int nh;
    int cnt;
    hits[0] = 0; hits[1] = 0; nh = 0; cnt = 0;
    lhs[k] = 8'h5A; rhs[k] = 8'h3C; cin[k] = 1'b1; sub[k] = 1'b0;
    in_valid[k] = 1'b1; out_ready[k] = 1'b1;
    while (nh < 2 && cnt < 60) begin
      step();
      cnt++;
      if (out_valid[k] === 1'b1) begin
        chk("tput_sum", 32'({cout[k], out[k]}), 32'(9'h097));
        hits[nh] = cnt;
        nh++;
      end
    end
    chk("tput_count", 32'(nh), 32'd2);
    chk("throughput", 32'(hits[1] - hits[0]), 32'(nd(k) + 2));
    in_valid[k] = 1'b0;
    step();
    chk("tput_idle", 32'({out_valid[k], in_ready[k]}), 32'd1);
    out_ready[k] = 1'b0;
  endtask

  // Handshakes seen at negedge complete on the following rising edge.
  task automatic monitor();
    logic [8:0] e;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      if (out_valid[k] && out_ready[k]) begin
        chk("queue_nonempty", 32'(wr_i[k] > rd_i[k]), 32'd1);
        if (wr_i[k] > rd_i[k]) begin
          e = exp_mem[k][rd_i[k] % 4096];
          rd_i[k]++;
          chk("rand_sum", 32'({cout[k], out[k]}), 32'(e));
        end
      end
      if (in_valid[k] && in_ready[k]) begin
        exp_mem[k][wr_i[k] % 4096] = model(lhs[k], rhs[k], cin[k], sub[k]);
        wr_i[k]++;
        total_acc++;
      end
    end
  endtask

  initial begin
    int cyc;
    clk = 1'b0;
    reset = 1'b1;
    checks = 0;
    failures = 0;
    total_acc = 0;
    for (int k = 0; k < NI; k++) begin
      wr_i[k] = 0;
      rd_i[k] = 0;
    end
    idle_all();

    tbl[0] = '{0, 8'hFF, 8'h01, 1'b0, 0, 9'h100};
    tbl[1] = '{0, 8'h3C, 8'h0F, 1'b1, 3, 9'h04C};
    tbl[2] = '{1, 8'h80, 8'h80, 1'b1, 0, 9'h101};
    tbl[3] = '{0, 8'h00, 8'h00, 1'b0, 1, 9'h000};
    tbl[4] = '{0, 8'hFF, 8'hFF, 1'b1, 0, 9'h1FF};
    tbl[5] = '{2, 8'hA5, 8'h5A, 1'b1, 2, 9'h100};
    tbl[6] = '{2, 8'h12, 8'h34, 1'b0, 0, 9'h046};
    tbl[7] = '{1, 8'hFF, 8'h00, 1'b1, 1, 9'h100};

    repeat (2) step();
    for (int k = 0; k < NI; k++)
      chk("reset_state", 32'({in_ready[k], out_valid[k], cout[k], out[k]}), 32'h400);
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      run_op(tbl[i].k, tbl[i].l, tbl[i].r, tbl[i].c, 1'b0, tbl[i].hold, tbl[i].e);

`ifdef SERIAL_ADDER_SUB_EN
    run_op(0, 8'h05, 8'h07, 1'b0, 1'b1, 0, 9'h0FE);
    run_op(2, 8'h40, 8'h10, 1'b1, 1'b1, 1, 9'h12F);
`endif

    // Reset in the second BUSY cycle aborts the operation.
    lhs[0] = 8'h11; rhs[0] = 8'h22; cin[0] = 1'b0; in_valid[0] = 1'b1;
    step();
    in_valid[0] = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_abort", 32'({in_ready[0], out_valid[0]}), 32'd2);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rst_no_result", 32'({in_ready[0], out_valid[0]}), 32'd2);
    end
    // Operands accepted on the first cycle after reset deasserts.
    reset = 1'b1;
    step();
    reset = 1'b0;
    run_op(0, 8'h7F, 8'h01, 1'b1, 1'b0, 0, 9'h081);

    for (int k = 0; k < NI; k++) tput(k);

    cyc = 0;
    while (total_acc < 1000 && cyc < 40000) begin
      for (int k = 0; k < NI; k++) begin
        lhs[k]       = 8'($urandom);
        rhs[k]       = 8'($urandom);
        cin[k]       = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
        sub[k]       = 1'($urandom);
`endif
        in_valid[k]  = 1'($urandom);
        out_ready[k] = 1'($urandom);
      end
      monitor();
      step();
      cyc++;
    end
    chk("random_budget", 32'(total_acc >= 1000), 32'd1);
    idle_all();
    for (int k = 0; k < NI; k++) out_ready[k] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      monitor();
      step();
    end
    for (int k = 0; k < NI; k++)
      chk("lost_ops", 32'(rd_i[k]), 32'(wr_i[k]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8: operand and sum width in bits.
REQ-002 Parameter DIGIT, default 2: bits added per cycle; WIDTH SHALL be an integer multiple of DIGIT, 1 <= DIGIT <= WIDTH.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 io_in_valid  input  1  operands valid.
REQ-006 io_in_ready  output  1  block can accept operands.
REQ-007 io_lhs  input  WIDTH  left operand.
REQ-008 io_rhs  input  WIDTH  right operand.
REQ-009 io_cin  input  1  carry-in.
REQ-010 io_out_valid  output  1  result valid.
REQ-011 io_out_ready  input  1  consumer accepts the result.
REQ-012 io_out  output  WIDTH  sum, lower WIDTH bits.
REQ-013 io_cout  output  1  carry-out, bit WIDTH of the full sum.

Function
REQ-014 The block SHALL compute {io_cout, io_out} = io_lhs + io_rhs + io_cin, zero-extended to WIDTH+1 bits, over N = WIDTH/DIGIT BUSY cycles.
REQ-015 States SHALL be IDLE, BUSY and DONE.
REQ-016 IDLE: io_in_ready=1 and io_out_valid=0; when io_in_valid=1, the block SHALL capture lhs, rhs and cin, clear the digit counter, and enter BUSY.
REQ-017 BUSY: each cycle SHALL add digit k of lhs, digit k of rhs and the carry register; it SHALL write the DIGIT-bit sum into result bits [k*DIGIT +: DIGIT], update the carry register, and increment k.
REQ-018 After digit N-1, the next state SHALL be DONE and io_cout SHALL take the final carry.
REQ-019 DONE: io_out_valid=1; io_out and io_cout SHALL stay stable until io_out_ready=1, after which the next state SHALL be IDLE.
REQ-020 Latency: for operands accepted at edge T, io_out_valid SHALL rise after edge T+N; for example, N=4 gives the result 4 cycles after acceptance.
REQ-021 io_in_ready SHALL be 0 in BUSY and DONE; io_in_valid in those states SHALL be ignored.
REQ-022 Captured operands SHALL be unaffected by changes on io_lhs, io_rhs or io_cin after acceptance.
REQ-023 Throughput: back-to-back operations with io_out_ready held high SHALL complete one every N+2 cycles.
REQ-024 DIGIT=WIDTH (N=1): BUSY SHALL last exactly one cycle; the digit counter SHALL be at least 1 bit wide.
REQ-025 Carry wrap: an all-ones sum plus carry SHALL give io_out=0 and io_cout=1, with no other side effect.

Reset
REQ-026 While reset=1 at a clock edge, the state SHALL become IDLE.
REQ-027 Reset SHALL clear the counter, carry register, io_out, io_cout and io_out_valid to 0, and drive io_in_ready=1 from the following cycle.
REQ-028 Reset asserted in BUSY or DONE SHALL abort the operation, and no result SHALL be presented.
REQ-029 The block SHALL accept new operands in the first cycle after reset deasserts.

Configuration
REQ-030 Macro SERIAL_ADDER_SUB_EN SHALL, when defined, add input io_sub (1 bit), captured with the operands.
REQ-031 With SERIAL_ADDER_SUB_EN defined and io_sub=1, the block SHALL compute lhs + ~rhs + ~cin, which is lhs - rhs - cin.
REQ-032 In that subtract case, io_cout=1 SHALL mean no borrow.
REQ-033 With SERIAL_ADDER_SUB_EN defined and io_sub=0, behaviour SHALL be as in REQ-014.
REQ-034 Without SERIAL_ADDER_SUB_EN, port io_sub SHALL NOT exist and the block SHALL only add.

Verification
REQ-035 Wrap test, WIDTH=8, DIGIT=2: lhs=0xFF, rhs=0x01, cin=0 accepted at T -> io_out_valid rises after T+4 with io_out=0x00, io_cout=1.
REQ-036 Backpressure test: lhs=0x3C, rhs=0x0F, cin=1 with io_out_ready low for 3 cycles in DONE -> io_out=0x4C and io_cout=0 held stable, io_in_ready=0 throughout, IDLE on the cycle after ready.
REQ-037 Reset test: reset pulsed on the 2nd BUSY cycle -> next cycle io_in_ready=1 and io_out_valid=0; io_out_valid SHALL never rise for the aborted operation.
REQ-038 Single-digit test, WIDTH=8, DIGIT=8: lhs=0x80, rhs=0x80, cin=1 -> io_out=0x01 and io_cout=1, one cycle after acceptance.
REQ-039 Subtract test, SERIAL_ADDER_SUB_EN defined, WIDTH=8, DIGIT=2: io_sub=1, lhs=0x05, rhs=0x07, cin=0 -> io_out=0xFE, io_cout=0.
REQ-040 Random test: 1000 random operand/cin/DIGIT combinations with random io_in_valid and io_out_ready -> every result matches the reference sum and no operation is lost or duplicated.
